// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU attribute writer: table selects, attribute
// word layout and the writer state encoding.
package ppu_pkg;

  localparam logic [7:0] TBL_ATTR   = 8'd0;
  localparam logic [7:0] TBL_SPRITE = 8'd1;
  localparam logic [7:0] TBL_COLOR  = 8'd2;

  localparam int unsigned ATTR_W    = 32;
  localparam int unsigned Y_LSB     = 0;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned X_LSB     = 10;
  localparam int unsigned X_W       = 10;
  localparam int unsigned SADDR_LSB = 20;
  localparam int unsigned SADDR_W   = 8;
  localparam int unsigned COLOR_LSB = 28;
  localparam int unsigned COLOR_W   = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [SADDR_W-1:0] saddr;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } attr_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } writer_state_e;

  // PPU bus address: table select in the high byte, entry index in the low byte.
  function automatic logic [15:0] ppu_addr(input logic [7:0] tbl, input logic [7:0] idx);
    return {tbl, idx};
  endfunction

endpackage

// File: rtl/attr_shadow.sv
// Shadow copy of the sprite attribute table with one dirty bit per entry.
// Game writes set dirty; the flush scan reads combinationally and clears it.
module attr_shadow
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  localparam int unsigned IW = $clog2(NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [ATTR_W-1:0] wr_data_i,
  input  logic              set_all_i,
  input  logic              clr_en_i,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [ATTR_W-1:0] rd_data_o,
  output logic              rd_dirty_o
);

  attr_word_t             mem_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dirty_q;
  logic [NUM_SPRITES-1:0] dirty_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= attr_word_t'(wr_data_i);
    end
  end

  // A clear only ever comes from the flush scan, which never overlaps a write.
  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      dirty_d[i] = (dirty_q[i] | set_all_i | (wr_en_i && (wr_idx_i == IW'(i))))
                   & ~(clr_en_i && (rd_idx_i == IW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_q <= '0;
    end else begin
      dirty_q <= dirty_d;
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/ppu_attr_writer.sv
// Flushes dirty sprite attributes to the PPU attribute table once per frame,
// starting on the first vertical-blank line, one bus write per cycle.
module ppu_attr_writer
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter logic [9:0]  VTRIG       = 10'd480,
  parameter logic [7:0]  ATTR_TABLE  = TBL_ATTR,
  localparam int unsigned IW = $clog2(NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        vcount,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [IW-1:0]     upd_index,
  input  logic [ATTR_W-1:0] upd_data,
  input  logic              flush_all,
  output logic              chipselect,
  output logic              write,
  output logic [15:0]       address,
  output logic [ATTR_W-1:0] writedata,
  output logic              busy,
  output logic              frame_done
);

  writer_state_e     state_q;
  writer_state_e     state_d;
  logic [IW-1:0]     scan_q;
  logic [IW-1:0]     scan_d;
  logic [9:0]        vcount_prev_q;
  logic              trig;
  logic              scan_last;
  logic              in_idle;
  logic              in_flush;
  logic [ATTR_W-1:0] rd_data;
  logic              rd_dirty;
  logic              cs_q;
  logic              wr_q;
  logic [15:0]       addr_q;
  logic [ATTR_W-1:0] wdata_q;

  assign trig      = (vcount == VTRIG) && (vcount_prev_q != VTRIG);
  assign scan_last = (scan_q == IW'(NUM_SPRITES - 1));
  assign in_idle   = (state_q == ST_IDLE);
  assign in_flush  = (state_q == ST_FLUSH);

  attr_shadow #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (upd_valid && in_idle),
    .wr_idx_i   (upd_index),
    .wr_data_i  (upd_data),
    .set_all_i  (flush_all && in_idle),
    .clr_en_i   (in_flush && rd_dirty),
    .rd_idx_i   (scan_q),
    .rd_data_o  (rd_data),
    .rd_dirty_o (rd_dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      scan_q        <= '0;
      vcount_prev_q <= 10'd0;
    end else begin
      state_q       <= state_d;
      scan_q        <= scan_d;
      vcount_prev_q <= vcount;
    end
  end

  // The flush always walks every index so its length never depends on the dirty count.
  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          scan_d  = '0;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (scan_last) begin
          state_d = ST_DONE;
        end else begin
          scan_d = scan_q + IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    upd_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        upd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_FLUSH: busy = 1'b1;
      ST_DONE:  frame_done = 1'b1;
      default: begin
        upd_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Address and data hold their last value between writes; only the strobes drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= '0;
    end else if (in_flush && rd_dirty) begin
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      addr_q  <= ppu_addr(ATTR_TABLE, 8'(scan_q));
      wdata_q <= rd_data;
    end else begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  assign chipselect = cs_q;
  assign write      = wr_q;
  assign address    = addr_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_ppu_attr_writer.sv
// Bench for ppu_attr_writer: a frame-level reference model predicts every
// cycle's bus and handshake outputs; directed scenarios add timing checks.
module tb_ppu_attr_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vcount;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_index;
  logic [31:0] upd_data;
  logic        flush_all;
  logic        chipselect;
  logic        write;
  logic [15:0] address;
  logic [31:0] writedata;
  logic        busy;
  logic        frame_done;

  ppu_attr_writer dut (
    .clk        (clk),
    .reset      (reset),
    .vcount     (vcount),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_index  (upd_index),
    .upd_data   (upd_data),
    .flush_all  (flush_all),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: shadow table, dirty flags, snapshot taken at the trigger.
  logic [31:0] m_shadow [16];
  bit          m_dirty  [16];
  logic [31:0] s_data   [16];
  bit          s_dirty  [16];
  int          m_t      = -1;
  logic [9:0]  m_vprev  = 10'd0;
  logic [15:0] m_addr   = 16'd0;
  logic [31:0] m_data   = 32'd0;
  logic [9:0]  vc_g     = 10'd0;

  typedef struct { int c; logic [15:0] a; logic [31:0] d; } wr_ev_t;
  wr_ev_t wlog[$];
  int     fd_log[$];
  int     hs_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit act;
    bit e_cs;
    int i;
    act  = (m_t >= 0) && (cyc >= m_t + 1) && (cyc <= m_t + 17);
    e_cs = 1'b0;
    if ((m_t >= 0) && (cyc >= m_t + 2) && (cyc <= m_t + 17)) begin
      i = cyc - m_t - 2;
      if (s_dirty[i]) begin
        e_cs   = 1'b1;
        m_addr = 16'(i);
        m_data = s_data[i];
      end
    end
    check_eq("upd_ready",  64'(upd_ready),  64'(!act));
    check_eq("busy",       64'(busy),       64'(act));
    check_eq("frame_done", 64'(frame_done), 64'((m_t >= 0) && (cyc == m_t + 17)));
    check_eq("chipselect", 64'(chipselect), 64'(e_cs));
    check_eq("write",      64'(write),      64'(e_cs));
    check_eq("address",    64'(address),    64'(m_addr));
    check_eq("writedata",  64'(writedata),  64'(m_data));
    if (chipselect === 1'b1) wlog.push_back('{cyc, address, writedata});
    if (frame_done === 1'b1) fd_log.push_back(cyc);
  endtask

  task automatic tick(input bit uv, input logic [3:0] ui, input logic [31:0] ud,
                      input bit fa, input bit rst);
    bit idle;
    bit trig;
    reset     = rst;
    vcount    = vc_g;
    upd_valid = uv;
    upd_index = ui;
    upd_data  = ud;
    flush_all = fa;
    if ((upd_valid === 1'b1) && (upd_ready === 1'b1)) hs_log.push_back(cyc);
    idle = !((m_t >= 0) && (cyc >= m_t + 1) && (cyc <= m_t + 17));
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_shadow[k] = 32'd0;
        m_dirty[k]  = 1'b0;
      end
      m_vprev = 10'd0;
      m_t     = -1;
      m_addr  = 16'd0;
      m_data  = 32'd0;
    end else begin
      if (idle && fa) for (int k = 0; k < 16; k++) m_dirty[k] = 1'b1;
      if (idle && uv) begin
        m_shadow[ui] = ud;
        m_dirty[ui]  = 1'b1;
      end
      trig = (vc_g == 10'd480) && (m_vprev != 10'd480);
      if (idle && trig) begin
        m_t = cyc;
        for (int k = 0; k < 16; k++) begin
          s_data[k]  = m_shadow[k];
          s_dirty[k] = m_dirty[k];
          m_dirty[k] = 1'b0;
        end
      end
      m_vprev = vc_g;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic post(input logic [3:0] i, input logic [31:0] d);
    tick(1'b1, i, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    vc_g = 10'd0;
    repeat (2) tick(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic trigger(output int t);
    vc_g = 10'd479;
    idle_n(1);
    vc_g = 10'd480;
    t = cyc;
    idle_n(1);
  endtask

  function automatic int wr_count(input int a, input int b);
    int n = 0;
    foreach (wlog[j]) if (wlog[j].c >= a && wlog[j].c <= b) n++;
    return n;
  endfunction

  function automatic int fd_count(input int a, input int b);
    int n = 0;
    foreach (fd_log[j]) if (fd_log[j] >= a && fd_log[j] <= b) n++;
    return n;
  endfunction

  function automatic int hs_count(input int a, input int b);
    int n = 0;
    foreach (hs_log[j]) if (hs_log[j] >= a && hs_log[j] <= b) n++;
    return n;
  endfunction

  task automatic expect_wr(input string tag, input int c, input logic [15:0] a, input logic [31:0] d);
    int k = -1;
    foreach (wlog[j]) if (wlog[j].c == c) k = j;
    check_eq({tag, "_present"}, 64'(k >= 0), 64'd1);
    if (k >= 0) begin
      check_eq({tag, "_addr"}, 64'(wlog[k].a), 64'(a));
      check_eq({tag, "_data"}, 64'(wlog[k].d), 64'(d));
    end
  endtask

  initial begin
    int t;
    int t2;
    bit uv;

    // Two updates, one flush.
    do_reset();
    post(4'd3, 32'h1234_5678);
    post(4'd9, 32'hA000_0000);
    trigger(t);
    idle_n(20);
    check_eq("s1_nwr", 64'(wr_count(t, t + 20)), 64'd2);
    expect_wr("s1_w3", t + 5, 16'h0003, 32'h1234_5678);
    expect_wr("s1_w9", t + 11, 16'h0009, 32'hA000_0000);
    check_eq("s1_fd_at", 64'(fd_count(t + 17, t + 17)), 64'd1);
    check_eq("s1_fd_n", 64'(fd_count(t, t + 20)), 64'd1);

    // flush_all only: sixteen back-to-back writes of zero.
    do_reset();
    tick(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    trigger(t);
    idle_n(20);
    check_eq("s2_nwr", 64'(wr_count(t, t + 20)), 64'd16);
    for (int i = 0; i < 16; i++) expect_wr("s2_w", t + 2 + i, 16'(i), 32'd0);
    check_eq("s2_fd_at", 64'(fd_count(t + 17, t + 17)), 64'd1);

    // Same index updated three times: last data, one write.
    do_reset();
    post(4'd5, 32'd1);
    post(4'd5, 32'd2);
    post(4'd5, 32'd3);
    trigger(t);
    idle_n(20);
    check_eq("s3_nwr", 64'(wr_count(t, t + 20)), 64'd1);
    expect_wr("s3_w5", t + 7, 16'h0005, 32'd3);

    // upd_valid held across the trigger.
    do_reset();
    post(4'd2, 32'h0000_2222);
    vc_g = 10'd479;
    tick(1'b1, 4'd7, 32'h0000_7777, 1'b0, 1'b0);
    vc_g = 10'd480;
    t = cyc;
    tick(1'b1, 4'd8, 32'h0000_8888, 1'b0, 1'b0);
    repeat (17) tick(1'b1, 4'd12, 32'h0000_CCCC, 1'b0, 1'b0);
    idle_n(5);
    check_eq("s4_hs_window", 64'(hs_count(t + 1, t + 17)), 64'd0);
    check_eq("s4_hs_at_t", 64'(hs_count(t, t)), 64'd1);
    check_eq("s4_nwr", 64'(wr_count(t, t + 22)), 64'd3);
    expect_wr("s4_w2", t + 4, 16'h0002, 32'h0000_2222);
    expect_wr("s4_w7", t + 9, 16'h0007, 32'h0000_7777);
    expect_wr("s4_w8", t + 10, 16'h0008, 32'h0000_8888);

    // Reset in T+6 of a full flush.
    do_reset();
    tick(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    trigger(t);
    idle_n(5);
    vc_g = 10'd0;
    tick(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    idle_n(25);
    check_eq("s5_wr_before", 64'(wr_count(t + 2, t + 6)), 64'd5);
    check_eq("s5_wr_after", 64'(wr_count(t + 7, t + 31)), 64'd0);
    check_eq("s5_fd", 64'(fd_count(t, t + 31)), 64'd0);
    trigger(t2);
    idle_n(20);
    check_eq("s5_next_nwr", 64'(wr_count(t2, t2 + 20)), 64'd0);
    check_eq("s5_next_fd", 64'(fd_count(t2 + 17, t2 + 17)), 64'd1);

    // vcount parked on the trigger line.
    do_reset();
    post(4'd1, 32'h0000_1111);
    vc_g = 10'd479;
    idle_n(1);
    vc_g = 10'd480;
    t = cyc;
    idle_n(1);
    repeat (1600) begin
      uv = ($urandom_range(0, 7) == 0);
      tick(uv, 4'($urandom_range(0, 15)), $urandom, 1'b0, 1'b0);
    end
    check_eq("s6_fd_hold", 64'(fd_count(t, t + 1601)), 64'd1);
    check_eq("s6_nwr_hold", 64'(wr_count(t, t + 1601)), 64'd1);
    expect_wr("s6_w1", t + 3, 16'h0001, 32'h0000_1111);
    vc_g = 10'd0;
    idle_n(1);
    vc_g = 10'd480;
    t2 = cyc;
    idle_n(20);
    check_eq("s6_fd_again", 64'(fd_count(t2 + 17, t2 + 17)), 64'd1);

    // Random traffic against the model.
    do_reset();
    repeat (900) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       vc_g = 10'd0;
          1:       vc_g = 10'd479;
          2:       vc_g = 10'd480;
          default: vc_g = 10'd481;
        endcase
      end
      tick(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
